pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register that replaces the fixed-field stage latch with stall-only hold. It carries a generic control bundle and data bundle between two pipeline stages using a valid/ready handshake. A two-entry skid buffer keeps `in_ready` fully registered, so there is no combinational path from `out_ready` to `in_ready`. It supports synchronous flush with bubble insertion and keeps saturating stall and bubble counters for performance analysis. One instance is used per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid.sv | 147 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer so in_ready is registered,
// plus synchronous flush and saturating stall/bubble performance counters.
module pipe_stage_skid #(
    parameter int                CTRL_W      = 16,
    parameter int                DATA_W      = 128,
    parameter int                CNT_W       = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // State bits are {main valid, skid valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [CTRL_W-1:0] main_ctrl_p0, skid_ctrl_p1;
    logic [DATA_W-1:0] main_data_p0, skid_data_p1;
    logic              rdy_q;

    logic accept, drain;
    logic ld_main_in, ld_main_skid, clr_main;
    logic ld_skid, clr_skid;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign out_valid = state_q[1];
    assign in_ready  = rdy_q;
    assign out_ctrl  = main_ctrl_p0;
    assign out_data  = main_data_p0;

    assign accept = in_valid & rdy_q;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != TWO);
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        clr_main     = 1'b0;
        ld_skid      = 1'b0;
        clr_skid     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    ld_main_in = 1'b1;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    ld_main_in = 1'b1;
                end else if (accept) begin
                    ld_skid = 1'b1;
                    state_d = TWO;
                end else if (drain) begin
                    clr_main = 1'b1;
                    state_d  = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    ld_main_skid = 1'b1;
                    clr_skid     = 1'b1;
                    state_d      = ONE;
                end
            end
            default: begin
                clr_main = 1'b1;
                clr_skid = 1'b1;
                state_d  = EMPTY;
            end
        endcase
        // Flush discards everything held and anything offered this cycle.
        if (Flush) begin
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
            clr_main     = 1'b1;
            clr_skid     = 1'b1;
            state_d      = EMPTY;
        end
    end

    // Stage p0: main register, drives the outputs
    always_ff @(posedge CLK) begin
        if (Reset || clr_main) begin
            main_ctrl_p0 <= BUBBLE_CTRL;
            main_data_p0 <= '0;
        end else if (ld_main_in) begin
            main_ctrl_p0 <= in_ctrl;
            main_data_p0 <= in_data;
        end else if (ld_main_skid) begin
            main_ctrl_p0 <= skid_ctrl_p1;
            main_data_p0 <= skid_data_p1;
        end
    end

    // Stage p1: skid register, absorbs the entry sent while downstream stalls
    always_ff @(posedge CLK) begin
        if (Reset || clr_skid) begin
            skid_ctrl_p1 <= BUBBLE_CTRL;
            skid_data_p1 <= '0;
        end else if (ld_skid) begin
            skid_ctrl_p1 <= in_ctrl;
            skid_data_p1 <= in_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
            if (!out_valid)              bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a queue scoreboard tracks held entries,
// expected handshake state and counters; a CNT_W=4 instance covers saturation.
module tb_pipe_stage_skid;

    localparam int             CW  = 16;
    localparam int             DW  = 32;
    localparam logic [CW-1:0]  BUB = 16'hB0B0;

    logic          CLK = 1'b0;
    logic          Reset, Flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cnt, bubble_cnt;

    logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [3:0]    s_stall_cnt, s_bubble_cnt;

    int compared   = 0;
    int mismatched = 0;
    logic [CW+DW-1:0] sb[$];
    int exp_stall, exp_bubble;
    logic acc;

    always #5 CLK = ~CLK;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16), .BUBBLE_CTRL(BUB)) dut (
        .CLK(CLK), .Reset(Reset), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4), .BUBBLE_CTRL(BUB)) sat_dut (
        .CLK(CLK), .Reset(Reset), .Flush(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(16'h0055), .in_data(32'h0000_0077),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the scoreboard, update the model, advance.
    task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic rdy, input logic fl, output logic a);
        int n;
        logic [CW+DW-1:0] fr;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = rdy;
        Flush     = fl;
        #1;
        n = sb.size();
        chk("out_valid", 64'(out_valid), 64'(n != 0));
        chk("in_ready", 64'(in_ready), 64'(n < 2));
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(exp_bubble));
        if (n == 0) begin
            chk("idle_ctrl", 64'(out_ctrl), 64'(BUB));
            chk("idle_data", 64'(out_data), 64'd0);
        end else begin
            fr = sb[0];
            chk("out_ctrl", 64'(out_ctrl), 64'(fr[DW +: CW]));
            chk("out_data", 64'(out_data), 64'(fr[DW-1:0]));
        end
        if (n != 0 && !rdy) exp_stall++;
        if (n == 0) exp_bubble++;
        if (n != 0 && rdy) void'(sb.pop_front());
        a = v && (n < 2);
        if (a && !fl) sb.push_back({c, d});
        if (fl) sb.delete();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic rdy);
        logic a;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, c, d, rdy, 1'b0, a);
            if (a) return;
        end
        compared++;
        mismatched++;
        $error("FAIL send_timeout observed=in_ready_low expected=accept_within_8");
    endtask

    task automatic idle(input int n, input logic rdy);
        logic a;
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, rdy, 1'b0, a);
    endtask

    task automatic do_reset();
        Reset      = 1'b1;
        Flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        s_in_valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        sb.delete();
        exp_stall  = 0;
        exp_bubble = 0;
    endtask

    task automatic chk_reset_values();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'(BUB));
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_bubble", 64'(bubble_cnt), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ctrl = '0; in_data = '0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        do_reset();
        chk_reset_values();

        // Streaming: two idle cycles then 8 back-to-back entries
        idle(2, 1'b1);
        for (int i = 0; i < 8; i++) send(CW'(i), DW'(i * 3), 1'b1);
        idle(2, 1'b1);
        chk("stream_stall", 64'(stall_cnt), 64'd0);
        chk("stream_bubble", 64'(bubble_cnt), 64'd4);

        // Backpressure: A on outputs, downstream stalls 3 cycles while B, C offered
        send(16'h000A, 32'hAAAA_0001, 1'b1);
        send(16'h000B, 32'hBBBB_0002, 1'b0);
        step(1'b1, 16'h000C, 32'hCCCC_0003, 1'b0, 1'b0, acc);
        chk("bp_c_blocked", 64'(acc), 64'd0);
        step(1'b1, 16'h000C, 32'hCCCC_0003, 1'b0, 1'b0, acc);
        #1;
        chk("bp_stall3", 64'(stall_cnt), 64'd3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head_A", 64'(out_ctrl), 64'h000A);
        send(16'h000C, 32'hCCCC_0003, 1'b1);
        send(16'h000D, 32'hDDDD_0004, 1'b1);
        idle(3, 1'b1);

        // Flush in TWO with C offered in the same cycle
        send(16'h00A2, 32'h1111_2222, 1'b0);
        send(16'h00B2, 32'h3333_4444, 1'b0);
        step(1'b1, 16'h00C2, 32'h5555_6666, 1'b0, 1'b1, acc);
        #1;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_out_ctrl", 64'(out_ctrl), 64'(BUB));
        chk("fl_out_data", 64'(out_data), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        idle(3, 1'b1);

        // Reset while full with stall_cnt=5
        do_reset();
        send(16'h00A3, 32'h0000_A3A3, 1'b0);
        send(16'h00B3, 32'h0000_B3B3, 1'b0);
        idle(4, 1'b0);
        #1;
        chk("pre_rst_stall5", 64'(stall_cnt), 64'd5);
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        do_reset();
        chk_reset_values();
        send(16'h00E0, 32'hE0E0_E0E0, 1'b1);
        idle(2, 1'b1);

        // Saturation on the CNT_W=4 instance
        do_reset();
        s_in_valid  = 1'b1;
        s_out_ready = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        s_in_valid = 1'b0;
        repeat (10) begin @(posedge CLK); @(negedge CLK); end
        chk("sat_stall10", 64'(s_stall_cnt), 64'd10);
        chk("sat_bubble_a", 64'(s_bubble_cnt), 64'd1);
        chk("sat_valid", 64'(s_out_valid), 64'd1);
        repeat (10) begin @(posedge CLK); @(negedge CLK); end
        chk("sat_stall15", 64'(s_stall_cnt), 64'd15);
        chk("sat_bubble_b", 64'(s_bubble_cnt), 64'd1);
        chk("sat_entry", 64'(s_out_data), 64'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
